fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised successor to the team's single-clock FIFO. It is generalised in width, depth and read mode, and adds:
- a selectable read mode: first-word-fall-through (show-ahead) or registered standard read
- an occupancy count output
- programmable almost-full and almost-empty thresholds
- write-on-full when a read is accepted in the same cycle

It sits between a streaming producer and consumer in one clock domain.

Parameters:
- DATA_WIDTH, 16, payload width in bits.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AFULL_THRESH, 12, almost_full asserts when count >= this; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this; legal range 0..DEPTH-1.
- FWFT, 1, 1 = show-ahead read, 0 = registered standard read.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write payload.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read payload.
- rd_valid  out  1  rd_data is meaningful (meaning depends on mode).
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Single clock: clk. Reset is asynchronous and active-low on rst_n.
- Accept rules:
  - pop = rd_en && !empty.
  - push = wr_en && (!full || pop).
- Full with rd_en and wr_en together: both are accepted; count is unchanged and both pointers advance.
- Empty with rd_en and wr_en together: only the write is accepted; there is no bypass. The data is readable from the next cycle.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Width is ADDR_WIDTH+1; it never over- or underflows.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- All flags decode combinationally from the registered count. They therefore reflect an edge's effect immediately after that edge.
- FWFT=1:
  - rd_data = mem[rd_ptr] continuously; rd_valid = !empty.
  - A pop consumes the displayed word; the next word appears after the same edge.
- FWFT=0:
  - On pop, rd_data <= mem[rd_ptr] at that edge, and rd_valid pulses high for exactly one cycle after the pop edge.
  - rd_data holds its last value while there is no pop.
- Reset (asynchronous, anytime, including mid-burst):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rd_valid = 0, rd_data = 0.
  - Memory contents are not cleared and are treated as discarded.
  - The first edge after rst_n deasserts operates normally.
- Elaboration fatal error if ADDR_WIDTH < 1, AFULL_THRESH is not in 1..DEPTH, or AEMPTY_THRESH is not in 0..DEPTH-1.
- Dropped requests (wr_en while full with no pop; rd_en while empty) have no effect on state.

Optional Feature:
FIFO_ERR_FLAGS_EN.
- Defined: adds port err_clr (in, 1) and sticky outputs overflow and underflow (out, 1 each), both reset to 0.
  - overflow sets on wr_en && full && !pop.
  - underflow sets on rd_en && empty.
  - err_clr clears both flags at the next edge. If a set and err_clr occur in the same cycle, the set wins.
- Undefined: these ports do not exist, and dropped requests are silent.

Decomposition:
- Package fifo_pkg:
  - default DATA_WIDTH and ADDR_WIDTH constants
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}, used to interpret FWFT
  - a threshold-check function used by the elaboration asserts
- Sub-module fifo_ram_sdp: simple dual-port storage array.
  - one write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - The control logic (pointers, count, flags, read register) stays in fifo_sync_param.

Test Plan:
- Reset then fill: 16 writes of 0x0001..0x0010 (FWFT=1) -> almost_full rises when count = 12; full = 1 after the 16th write; a 17th write is dropped and count stays 16; overflow = 1 if FIFO_ERR_FLAGS_EN is defined.
- Drain, FWFT=1: from full, hold rd_en for 16 cycles -> rd_data shows 0x0001..0x0010 in order, one per cycle; almost_empty rises when count = 2; empty = 1 and rd_valid = 0 at the end.
- Drain, FWFT=0: write 0xA5A5 and 0x5A5A, then pulse rd_en twice -> rd_valid is high on the cycles after each pop with 0xA5A5 then 0x5A5A; rd_data holds 0x5A5A afterwards.
- Simultaneous access: at full, assert rd_en and wr_en together with wr_data = 0xBEEF -> count stays 16, full stays 1, and 0xBEEF is the last word read out. At empty, rd_en + wr_en -> count = 1 and underflow = 1 (if the feature is enabled).
- Wrap-around: 10 writes, 10 reads, 10 writes, 10 reads with incrementing data -> order is preserved across pointer wrap; count returns to 0.
- Reset mid-operation: with count = 7, pulse rst_n low asynchronously between edges -> all outputs reach reset values immediately; a subsequent write/read pair returns the new data only.

Source files
------------

// File: rtl/fifo_sync_param_pkg.sv
// fifo_pkg: shared definitions for the parametrised single-clock FIFO.
//   DefaultDataWidth / DefaultAddrWidth : default payload and pointer widths
//   fifo_mode_e                         : read-mode encoding for the FWFT parameter
//   fifo_cfg_ok()                       : legality check for width/threshold parameters
package fifo_pkg;

   localparam int unsigned DefaultDataWidth = 16;
   localparam int unsigned DefaultAddrWidth = 4;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // True when the pointer width and both thresholds describe a usable FIFO.
   function automatic bit fifo_cfg_ok(input int addr_width, input int afull_thresh,
                                      input int aempty_thresh);
      int depth;
      if (addr_width < 1 || addr_width > 30) return 1'b0;
      depth = 1 << addr_width;
      return (afull_thresh >= 1) && (afull_thresh <= depth) &&
             (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer handshake bundle for fifo_sync_param.
//   master modport : user side (drives wr_en, wr_data, rd_en[, err_clr])
//   slave modport  : FIFO side (drives full, almost_full, rd_data, rd_valid, empty,
//                    almost_empty, count[, overflow, underflow])
// Optional macro FIFO_ERR_FLAGS_EN adds err_clr, overflow and underflow.
interface fifo_sync_param_if #(
   parameter int unsigned DATA_WIDTH = fifo_pkg::DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = fifo_pkg::DefaultAddrWidth
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
   logic                  err_clr;
   logic                  overflow;
   logic                  underflow;
`endif

   modport master (
      output wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
      output err_clr,
      input  overflow, underflow,
`endif
      input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
      input  err_clr,
      output overflow, underflow,
`endif
      output full, almost_full, rd_data, rd_valid, empty, almost_empty, count
   );
endinterface

// File: rtl/fifo_ram_sdp.sv
// fifo_ram_sdp: simple dual-port storage array, synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable; waddr/wdata : write address and data
//   raddr : read address; rdata : combinational read data
// Contents are never reset.
module fifo_ram_sdp #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with show-ahead or registered read.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : fifo_sync_param_if.slave (write/read handshakes, flags, count)
// FWFT=1 presents the head word combinationally; FWFT=0 registers it on each pop.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags with err_clr.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH    = DefaultAddrWidth,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int          AEMPTY_THRESH = 2,
   parameter int unsigned FWFT          = 1
) (
   input logic             clk,
   input logic             rst_n,
   fifo_sync_param_if.slave bus
);
   localparam fifo_mode_e Mode = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [ADDR_WIDTH:0] DepthCnt  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AfullCnt  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AemptyCnt = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

   if (!fifo_cfg_ok(int'(ADDR_WIDTH), int'(AFULL_THRESH), AEMPTY_THRESH)) begin : g_cfg_err
      $fatal(1, "fifo_sync_param: illegal ADDR_WIDTH/AFULL_THRESH/AEMPTY_THRESH");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full, empty, push, pop;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Flags decode straight from the registered count.
   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   assign pop   = bus.rd_en && !empty;
   // A write into a full FIFO is accepted when a read frees a slot at the same edge.
   assign push  = bus.wr_en && (!full || pop);

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fifo_ram_sdp #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (push),
      .waddr(wr_ptr_q),
      .wdata(bus.wr_data),
      .raddr(rd_ptr_q),
      .rdata(ram_rdata)
   );

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AfullCnt);
   assign bus.almost_empty = (count_q <= AemptyCnt);
   assign bus.count        = count_q;

   if (Mode == FIFO_FWFT) begin : g_fwft
      // Masked while empty so stale memory never shows and reset reads back zero.
      assign bus.rd_data  = empty ? '0 : ram_rdata;
      assign bus.rd_valid = !empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= pop;
            if (pop) rd_data_q <= ram_rdata;
         end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   // Setting has priority over err_clr in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr_en && full && !pop) overflow_q <= 1'b1;
         else if (bus.err_clr)          overflow_q <= 1'b0;
         if (bus.rd_en && empty)        underflow_q <= 1'b1;
         else if (bus.err_clr)          underflow_q <= 1'b0;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: one FWFT=1 and one FWFT=0 instance share the same stimulus and
// are compared against a queue-based reference model plus directed vector tables.
module tb_fifo_sync_param;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_f ();
   fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_s ();

   assign bus_f.wr_en   = wr_en;
   assign bus_f.wr_data = wr_data;
   assign bus_f.rd_en   = rd_en;
   assign bus_s.wr_en   = wr_en;
   assign bus_s.wr_data = wr_data;
   assign bus_s.rd_en   = rd_en;
`ifdef FIFO_ERR_FLAGS_EN
   assign bus_f.err_clr = err_clr;
   assign bus_s.err_clr = err_clr;
`endif

   fifo_sync_param #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1)
   ) u_fwft (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_f)
   );

   fifo_sync_param #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(0)
   ) u_std (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_s)
   );

   // Reference model state.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_sdata;
   bit            m_svalid;
   bit            m_ovf;
   bit            m_udf;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit            we;
      logic [DW-1:0] wd;
      bit            re;
      int            ecount;
      bit            efull;
      bit            eafull;
      bit            eaempty;
      bit            eempty;
      logic [DW-1:0] ehead;
   } vec_t;

   vec_t tbl[33];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_sdata  = '0;
      m_svalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
   endtask

   task automatic model_step();
      int n;
      bit pop, push, oset, uset;
      n    = m_q.size();
      pop  = rd_en && (n > 0);
      push = wr_en && ((n < DEPTH) || pop);
      oset = wr_en && (n == DEPTH) && !pop;
      uset = rd_en && (n == 0);
      if (oset) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (uset) m_udf = 1'b1;
      else if (err_clr) m_udf = 1'b0;
      m_svalid = pop;
      if (pop) m_sdata = m_q.pop_front();
      if (push) m_q.push_back(wr_data);
   endtask

   task automatic check_model(input string tag);
      int n;
      n = m_q.size();
      chk({tag, ".count"}, 32'(bus_f.count), n);
      chk({tag, ".full"}, 32'(bus_f.full), 32'(n == DEPTH));
      chk({tag, ".afull"}, 32'(bus_f.almost_full), 32'(n >= AF));
      chk({tag, ".aempty"}, 32'(bus_f.almost_empty), 32'(n <= AE));
      chk({tag, ".empty"}, 32'(bus_f.empty), 32'(n == 0));
      chk({tag, ".fwft_valid"}, 32'(bus_f.rd_valid), 32'(n > 0));
      if (n > 0) chk({tag, ".fwft_data"}, 32'(bus_f.rd_data), 32'(m_q[0]));
      chk({tag, ".std_count"}, 32'(bus_s.count), n);
      chk({tag, ".std_valid"}, 32'(bus_s.rd_valid), 32'(m_svalid));
      chk({tag, ".std_data"}, 32'(bus_s.rd_data), 32'(m_sdata));
`ifdef FIFO_ERR_FLAGS_EN
      chk({tag, ".overflow"}, 32'(bus_f.overflow), 32'(m_ovf));
      chk({tag, ".underflow"}, 32'(bus_f.underflow), 32'(m_udf));
      chk({tag, ".std_overflow"}, 32'(bus_s.overflow), 32'(m_ovf));
`endif
   endtask

   // Apply the given inputs across one rising edge, then settle 1 time unit.
   task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".count"}, 32'(bus_f.count), 0);
      chk({tag, ".empty"}, 32'(bus_f.empty), 1);
      chk({tag, ".aempty"}, 32'(bus_f.almost_empty), 1);
      chk({tag, ".full"}, 32'(bus_f.full), 0);
      chk({tag, ".afull"}, 32'(bus_f.almost_full), 0);
      chk({tag, ".fwft_valid"}, 32'(bus_f.rd_valid), 0);
      chk({tag, ".fwft_data"}, 32'(bus_f.rd_data), 0);
      chk({tag, ".std_valid"}, 32'(bus_s.rd_valid), 0);
      chk({tag, ".std_data"}, 32'(bus_s.rd_data), 0);
      chk({tag, ".std_count"}, 32'(bus_s.count), 0);
`ifdef FIFO_ERR_FLAGS_EN
      chk({tag, ".overflow"}, 32'(bus_f.overflow), 0);
      chk({tag, ".underflow"}, 32'(bus_f.underflow), 0);
`endif
   endtask

   initial begin
      logic [DW-1:0] rd_exp;
      logic [DW-1:0] wr_val;

      // Fill (16 writes + one dropped write) then drain, with spec-derived expectations.
      for (int i = 0; i < 16; i++) begin
         tbl[i].we = 1'b1; tbl[i].wd = DW'(i + 1); tbl[i].re = 1'b0;
         tbl[i].ecount = i + 1;
         tbl[i].efull = (i + 1 == 16); tbl[i].eafull = (i + 1 >= 12);
         tbl[i].eaempty = (i + 1 <= 2); tbl[i].eempty = 1'b0;
         tbl[i].ehead = 16'h0001;
      end
      tbl[16].we = 1'b1; tbl[16].wd = 16'hDEAD; tbl[16].re = 1'b0; tbl[16].ecount = 16;
      tbl[16].efull = 1'b1; tbl[16].eafull = 1'b1; tbl[16].eaempty = 1'b0;
      tbl[16].eempty = 1'b0; tbl[16].ehead = 16'h0001;
      for (int k = 1; k <= 16; k++) begin
         tbl[16+k].we = 1'b0; tbl[16+k].wd = '0; tbl[16+k].re = 1'b1;
         tbl[16+k].ecount = 16 - k;
         tbl[16+k].efull = 1'b0; tbl[16+k].eafull = (16 - k >= 12);
         tbl[16+k].eaempty = (16 - k <= 2); tbl[16+k].eempty = (k == 16);
         tbl[16+k].ehead = DW'(k + 1);
      end

      // Reset state, asserted from time zero.
      model_reset();
      #12;
      check_reset_values("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 33; i++) begin
         drive(tbl[i].we, tbl[i].wd, tbl[i].re);
         chk($sformatf("tbl%0d.count", i), 32'(bus_f.count), tbl[i].ecount);
         chk($sformatf("tbl%0d.full", i), 32'(bus_f.full), 32'(tbl[i].efull));
         chk($sformatf("tbl%0d.afull", i), 32'(bus_f.almost_full), 32'(tbl[i].eafull));
         chk($sformatf("tbl%0d.aempty", i), 32'(bus_f.almost_empty), 32'(tbl[i].eaempty));
         chk($sformatf("tbl%0d.empty", i), 32'(bus_f.empty), 32'(tbl[i].eempty));
         if (!tbl[i].eempty)
            chk($sformatf("tbl%0d.head", i), 32'(bus_f.rd_data), 32'(tbl[i].ehead));
`ifdef FIFO_ERR_FLAGS_EN
         if (i == 16) chk("fill.overflow", 32'(bus_f.overflow), 1);
`endif
         check_model($sformatf("tbl%0d", i));
      end

      // Clear sticky flags.
      err_clr = 1'b1;
      drive(1'b0, '0, 1'b0);
      err_clr = 1'b0;
      check_model("clr0");

      // Simultaneous read+write at full.
      for (int i = 0; i < 16; i++) drive(1'b1, DW'(16'h0100 + i), 1'b0);
      drive(1'b1, 16'hBEEF, 1'b1);
      chk("full_rw.count", 32'(bus_f.count), 16);
      chk("full_rw.full", 32'(bus_f.full), 1);
      check_model("full_rw");
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, '0, 1'b1);
         check_model("full_rw_drain");
      end
      chk("full_rw.last", 32'(bus_s.rd_data), 32'h0000BEEF);

      // Simultaneous read+write at empty: only the write lands.
      drive(1'b1, 16'h0042, 1'b1);
      chk("empty_rw.count", 32'(bus_f.count), 1);
      chk("empty_rw.head", 32'(bus_f.rd_data), 32'h0042);
`ifdef FIFO_ERR_FLAGS_EN
      chk("empty_rw.underflow", 32'(bus_f.underflow), 1);
`endif
      check_model("empty_rw");
      err_clr = 1'b1;
      drive(1'b0, '0, 1'b1);
      err_clr = 1'b0;
      check_model("empty_rw_drain");

      // Registered-read pulses.
      drive(1'b1, 16'hA5A5, 1'b0);
      drive(1'b1, 16'h5A5A, 1'b0);
      drive(1'b0, '0, 1'b1);
      chk("std.pop1_valid", 32'(bus_s.rd_valid), 1);
      chk("std.pop1_data", 32'(bus_s.rd_data), 32'hA5A5);
      drive(1'b0, '0, 1'b0);
      chk("std.gap_valid", 32'(bus_s.rd_valid), 0);
      chk("std.gap_data", 32'(bus_s.rd_data), 32'hA5A5);
      drive(1'b0, '0, 1'b1);
      chk("std.pop2_valid", 32'(bus_s.rd_valid), 1);
      chk("std.pop2_data", 32'(bus_s.rd_data), 32'h5A5A);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("std.hold_valid", 32'(bus_s.rd_valid), 0);
      chk("std.hold_data", 32'(bus_s.rd_data), 32'h5A5A);
      check_model("std_seq");

      // Wrap-around: 10/10/10/10 with incrementing data.
      wr_val = 16'h1000;
      rd_exp = 16'h1000;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 10; i++) begin
            drive(1'b1, wr_val, 1'b0);
            wr_val++;
            check_model("wrap_w");
         end
         for (int i = 0; i < 10; i++) begin
            chk("wrap.head", 32'(bus_f.rd_data), 32'(rd_exp));
            drive(1'b0, '0, 1'b1);
            chk("wrap.std_data", 32'(bus_s.rd_data), 32'(rd_exp));
            rd_exp++;
            check_model("wrap_r");
         end
      end
      chk("wrap.count", 32'(bus_f.count), 0);

      // Asynchronous reset with 7 entries stored.
      for (int i = 0; i < 7; i++) drive(1'b1, DW'(16'h0700 + i), 1'b0);
      drive(1'b0, '0, 1'b1);
      chk("prerst.count", 32'(bus_f.count), 6);
      chk("prerst.std_valid", 32'(bus_s.rd_valid), 1);
      drive(1'b1, 16'h0707, 1'b0);
      chk("prerst.count7", 32'(bus_f.count), 7);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values("midrst");
      #2;
      rst_n = 1'b1;
      drive(1'b1, 16'h1234, 1'b0);
      chk("postrst.count", 32'(bus_f.count), 1);
      chk("postrst.head", 32'(bus_f.rd_data), 32'h1234);
      drive(1'b0, '0, 1'b1);
      chk("postrst.std_data", 32'(bus_s.rd_data), 32'h1234);
      chk("postrst.empty", 32'(bus_f.empty), 1);
      check_model("postrst");

      // Randomized traffic with alternating fill/drain bias.
      for (int c = 0; c < 3000; c++) begin
         int wbias;
         wbias   = ((c / 150) % 2 == 0) ? 75 : 25;
         err_clr = ($urandom_range(0, 15) == 0);
         drive($urandom_range(0, 99) < wbias, DW'($urandom), $urandom_range(0, 99) >= wbias);
         check_model("rand");
      end
      err_clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
